imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 83 ++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte receiver handshake, pipeline control and instruction-memory write bus
interface imem_loader_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        i_halt;
    logic        o_write_en;
    logic [31:0] o_data;
    logic [31:0] o_addr_wr;
    logic        o_read_en;
    logic        o_stall;
    logic        o_load_full;
    logic [2:0]  o_state;

    modport master (
        output i_rx_data, i_rx_valid, i_halt,
        input  o_rx_ready, o_write_en, o_data, o_addr_wr, o_read_en, o_stall, o_load_full, o_state
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_halt,
        output o_rx_ready, o_write_en, o_data, o_addr_wr, o_read_en, o_stall, o_load_full, o_state
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: serial command decoder that loads instruction memory and gates pipeline run/step
module imem_loader #(
    parameter int          IMEM_DEPTH_WORDS = 256,
    parameter logic [31:0] HALT_WORD        = 32'hFFFFFFFF
) (
    input logic         i_clk,
    input logic         i_reset,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, STEP} state_t;

    localparam logic [31:0] LAST_ADDR = 32'((IMEM_DEPTH_WORDS - 1) * 4);

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] addr;
    logic [31:0] word_buf;
    logic        fire;

    assign bus.o_rx_ready = (state == IDLE) || (state == LOAD) || (state == RUN);
    assign bus.o_write_en = state == WRITE;
    assign bus.o_read_en  = (state == RUN) || (state == STEP);
    assign bus.o_stall    = !bus.o_read_en;
    assign bus.o_state    = state;
    assign fire           = bus.i_rx_valid && bus.o_rx_ready;

    // Command decode, little-endian word assembly, write sequencing and run control
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state           <= IDLE;
            cnt             <= 2'd0;
            addr            <= 32'd0;
            word_buf        <= 32'd0;
            bus.o_data      <= 32'd0;
            bus.o_addr_wr   <= 32'd0;
            bus.o_load_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        case (bus.i_rx_data)
                            8'h01: begin
                                state           <= LOAD;
                                addr            <= 32'd0;
                                cnt             <= 2'd0;
                                bus.o_load_full <= 1'b0;
                            end
                            8'h02:   state <= RUN;
                            8'h03:   state <= STEP;
                            default: state <= IDLE;
                        endcase
                    end
                end
                LOAD: begin
                    if (fire) begin
                        word_buf <= {bus.i_rx_data, word_buf[31:8]};
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state         <= WRITE;
                            bus.o_data    <= {bus.i_rx_data, word_buf[31:8]};
                            bus.o_addr_wr <= addr;
                        end
                    end
                end
                WRITE: begin
                    if (bus.o_data == HALT_WORD) begin
                        state <= IDLE;
                    end else if (addr == LAST_ADDR) begin
                        state           <= IDLE;
                        bus.o_load_full <= 1'b1;
                    end else begin
                        state <= LOAD;
                        addr  <= addr + 32'd4;
                    end
                end
                RUN: begin
                    if (bus.i_halt || (fire && bus.i_rx_data == 8'h04)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of load, capacity, run/halt, step, backpressure and reset
module tb_imem_loader;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   waits;
    logic [31:0] wr_data[$];
    logic [31:0] wr_addr[$];

    imem_loader_if bus();

    imem_loader #(.IMEM_DEPTH_WORDS(4)) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every memory write strobe seen mid-cycle
    always @(negedge clk) begin
        if (bus.o_write_en === 1'b1) begin
            wr_data.push_back(bus.o_data);
            wr_addr.push_back(bus.o_addr_wr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        while (bus.o_rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        if (n == 20) begin
            total++;
            $error("FAIL rx_ready_timeout: observed ready low for %0d cycles expected high", n);
        end
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(bus.o_state), 32'd0);
        chk({tag, "_stall"}, 32'(bus.o_stall), 32'd1);
        chk({tag, "_ready"}, 32'(bus.o_rx_ready), 32'd1);
        chk({tag, "_wen"}, 32'(bus.o_write_en), 32'd0);
        chk({tag, "_ren"}, 32'(bus.o_read_en), 32'd0);
        chk({tag, "_data"}, bus.o_data, 32'd0);
        chk({tag, "_addr"}, bus.o_addr_wr, 32'd0);
        chk({tag, "_full"}, 32'(bus.o_load_full), 32'd0);
    endtask

    initial begin
        logic [7:0] prog[12];
        total = 0;
        passed = 0;
        waits = 0;
        rst_n = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_halt     = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic load ending on the halt word
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h22, 8'h22, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send(8'h01);
        chk("load_state", 32'(bus.o_state), 32'd1);
        for (int i = 0; i < 12; i++) send(prog[i]);
        chk("halt_write_state", 32'(bus.o_state), 32'd2);
        chk("halt_write_en", 32'(bus.o_write_en), 32'd1);
        chk("halt_write_ready", 32'(bus.o_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("load_done_state", 32'(bus.o_state), 32'd0);
        chk("load_done_full", 32'(bus.o_load_full), 32'd0);
        chk("load_writes", 32'(wr_data.size()), 32'd3);
        if (wr_data.size() == 3) begin
            chk("w0_data", wr_data[0], 32'h00000013);
            chk("w0_addr", wr_addr[0], 32'd0);
            chk("w1_data", wr_data[1], 32'h22220005);
            chk("w1_addr", wr_addr[1], 32'd4);
            chk("w2_data", wr_data[2], 32'hFFFFFFFF);
            chk("w2_addr", wr_addr[2], 32'd8);
        end
        chk("hold_data", bus.o_data, 32'hFFFFFFFF);
        chk("hold_addr", bus.o_addr_wr, 32'd8);

        // Capacity stop after four words; fifth word's bytes become commands
        wr_data.delete();
        wr_addr.delete();
        send(8'h01);
        for (int k = 1; k <= 4; k++) begin
            send(8'(k));
            if (k == 2) chk("backpressure_wait", 32'(waits), 32'd1);
            send(8'h00);
            send(8'h00);
            send(8'h00);
        end
        @(posedge clk);
        #1;
        chk("cap_state", 32'(bus.o_state), 32'd0);
        chk("cap_full", 32'(bus.o_load_full), 32'd1);
        chk("cap_writes", 32'(wr_data.size()), 32'd4);
        if (wr_data.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cap_w%0d_data", k), wr_data[k], 32'(k + 1));
                chk($sformatf("cap_w%0d_addr", k), wr_addr[k], 32'(4 * k));
            end
        end
        send(8'h55);
        send(8'h66);
        send(8'h77);
        chk("cap_extra_idle", 32'(bus.o_state), 32'd0);
        send(8'h02);
        chk("cap_extra_run", 32'(bus.o_state), 32'd3);
        chk("cap_no_more_writes", 32'(wr_data.size()), 32'd4);
        chk("cap_full_sticky", 32'(bus.o_load_full), 32'd1);
        send(8'h04);
        chk("stop_cmd_state", 32'(bus.o_state), 32'd0);

        // Run, ignore bytes while running, halt from the pipeline
        send(8'h02);
        chk("run_state", 32'(bus.o_state), 32'd3);
        chk("run_stall", 32'(bus.o_stall), 32'd0);
        chk("run_ren", 32'(bus.o_read_en), 32'd1);
        send(8'h01);
        chk("run_ignores_load", 32'(bus.o_state), 32'd3);
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.i_halt = 1'b1;
        @(posedge clk);
        #1;
        bus.i_halt = 1'b0;
        chk("halt_state", 32'(bus.o_state), 32'd0);
        chk("halt_stall", 32'(bus.o_stall), 32'd1);
        chk("halt_ren", 32'(bus.o_read_en), 32'd0);

        // Stop byte and pipeline halt in the same cycle
        send(8'h02);
        chk("run2_state", 32'(bus.o_state), 32'd3);
        @(negedge clk);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'h04;
        bus.i_halt     = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        bus.i_halt     = 1'b0;
        chk("coinc_state", 32'(bus.o_state), 32'd0);
        @(posedge clk);
        #1;
        chk("coinc_stays_idle", 32'(bus.o_state), 32'd0);

        // Single step with halt held high throughout
        @(negedge clk);
        bus.i_halt = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_halt_ignored", 32'(bus.o_state), 32'd0);
        send(8'h03);
        chk("step_state", 32'(bus.o_state), 32'd4);
        chk("step_stall", 32'(bus.o_stall), 32'd0);
        chk("step_ren", 32'(bus.o_read_en), 32'd1);
        chk("step_ready", 32'(bus.o_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("step_done_state", 32'(bus.o_state), 32'd0);
        chk("step_done_stall", 32'(bus.o_stall), 32'd1);
        bus.i_halt = 1'b0;

        // Reset while idle clears the sticky flag and the held write bus
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_idle");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the write cycle
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        chk("pre_rst_write", 32'(bus.o_write_en), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_write");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-word; next byte must be taken as a command
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h02);
        chk("post_rst_run", 32'(bus.o_state), 32'd3);
        send(8'h04);
        chk("post_rst_idle", 32'(bus.o_state), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
